sat_accumulator: RTL and testbench
==================================

Name: sat_accumulator

Overview:
- Downstream consumer of the saturating fixed-point adder and multiplier stages in the systolic array.
- Accumulates a vector of `len` signed fixed-point terms, for example the partial products of one PE column, into a wider saturating accumulator.
- Emits one result per vector with a `done` pulse and a per-vector overflow flag.
- Keeps the array's en/stall/done handshake: `stall` freezes all state, `done` marks valid output.

Parameters:
- IN_WIDTH, 16, input word width (signed two's complement).
- IN_FRAC, 15, input fractional bits.
- OUTPUT_WIDTH, 32, accumulator/output width; must be >= IN_WIDTH.
- OUTPUT_FRAC, 15, accumulator fractional bits.
- LEN_WIDTH, 8, width of the vector-length field.
- DELAY, 1, output latency in cycles after the final beat; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  input beat valid.
- stall  in  1  freeze all state and outputs.
- clear  in  1  synchronous abort of the current vector.
- data_in  in  IN_WIDTH  signed input term.
- len  in  LEN_WIDTH  terms per vector; sampled on the first beat only.
- acc_out  out  OUTPUT_WIDTH  accumulated result.
- done  out  1  acc_out valid.
- overflow  out  1  saturation occurred in the vector reported with done.
- busy  out  1  vector in progress (state ACCUM).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; accumulator, counter, acc_out, done, overflow, busy all 0.
  - All delay-line stages are 0.
  - Reset mid-vector discards the partial sum; no done is produced.
- Beat acceptance: a beat is accepted when `en && !stall && !clear`. No other input is consumed.
- Alignment:
  - data_in is sign-extended to OUTPUT_WIDTH.
  - It is then shifted arithmetically left by (OUTPUT_FRAC-IN_FRAC), or right by the negated amount if that is negative.
  - A shift of OUTPUT_WIDTH or more yields the sign fill.
- Summation and saturation:
  - Sum is formed in OUTPUT_WIDTH+1 bits.
  - It is clamped to MAX=0111..1 or MIN=100..0.
  - Any clamp sets the sticky vector-overflow bit.
- State machine:
  - IDLE, on accepted beat:
    - acc = aligned(data_in), i.e. a load, not an add.
    - Latch eff_len = (len==0) ? 1 : len; count = 1; ovf = 0.
    - If eff_len==1, the vector completes this beat and state stays IDLE.
    - Otherwise state goes to ACCUM.
  - ACCUM, on accepted beat:
    - acc = sat(acc + aligned(data_in)); count++.
    - When count reaches eff_len, the vector completes and state goes to IDLE.
  - ACCUM with no accepted beat: hold all state.
- Completion:
  - On the completing beat, the final saturated sum and ovf enter the output delay line with a valid bit.
  - With DELAY=1, acc_out, overflow and done update on the next edge.
  - Each extra DELAY stage adds one cycle; every stage holds while stall=1.
  - done is high for exactly one non-stalled cycle per vector, and stays high while stall holds it.
  - acc_out and overflow keep their last value when done=0.
- Back-to-back vectors:
  - A beat accepted in IDLE in the cycle after completion starts a new vector with zero bubbles.
  - Consecutive done pulses are allowed.
- Clear:
  - clear=1 forces state=IDLE, acc=0, count=0, ovf=0, regardless of stall.
  - The delay line is not flushed, so results already completed still emerge.
  - clear has priority over en in the same cycle; that beat is dropped.
- Stall: the state, accumulator, counter and delay line all hold; en is ignored.
- len changes while in ACCUM are ignored.
- busy = (state==ACCUM).

Decomposition:
- Shared package `sa_fixed_pkg`:
  - state enum {IDLE, ACCUM};
  - MAX/MIN saturation constant functions parameterised by width;
  - align(value, shift) and sat_clamp(sum_ext) functions, reused by adder and multiplier stages.
- Sub-module `stall_delay_line`:
  - parameters WIDTH and DEPTH;
  - carries {valid, overflow, result} through DELAY-1 stall-aware registers with async active-low reset;
  - DEPTH=0 is a pass-through.

Test Plan:
- len=4, data_in=0x4000 (0.5) ×4 on consecutive cycles, DELAY=1 → done one cycle after the 4th beat, acc_out=65536 (2.0 at frac 15), overflow=0, busy high for 3 cycles.
- OUTPUT_WIDTH=16, OUTPUT_FRAC=15, len=2, data_in 0x7000 then 0x7000 → acc_out=0x7FFF, overflow=1; next vector len=1, 0x0001 → acc_out=0x0001, overflow=0.
- Back-to-back len=2 vectors {1,2}{3,4}, plus en gapped one cycle inside the second → done pulses carry 3 then 7; the gap delays the second done by one cycle.
- len=3 with stall=1 for 3 cycles after beat 2 (en held high) → the stalled en beats are not counted; result equals the unstalled sum, done arrives 3 cycles later; with DELAY=3, a stall while done=1 holds done and acc_out.
- clear asserted with en after 2 of len=4 beats, then a fresh len=2 vector {5,6} → no done for the aborted vector; next done acc_out=11.
- reset_n pulsed low mid-ACCUM, asynchronously between edges → all outputs 0 immediately; a subsequent len=1 vector with 0xFFFF (-1 LSB) → acc_out=all-ones (sign-extended -1 LSB).

Source files
------------

// File: rtl/sa_fixed_pkg.sv
// Fixed-point helpers shared by the systolic-array arithmetic stages.
// Functions work on wide signed values; callers truncate to their width.
package sa_fixed_pkg;

    localparam int MAXW = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef logic signed [MAXW-1:0] wide_t;

    typedef struct packed {
        logic  ovf;
        wide_t val;
    } sat_t;

    function automatic wide_t sat_max(input int width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int width);
        return ~sat_max(width);
    endfunction

    // Oversized shifts in either direction collapse to the sign fill.
    function automatic wide_t align(
        input wide_t value,
        input int    shift,
        input int    width
    );
        wide_t res;
        if (shift >= width || -shift >= width)
            res = {MAXW{value[MAXW-1]}};
        else if (shift >= 0)
            res = value <<< shift;
        else
            res = value >>> (-shift);
        return res;
    endfunction

    function automatic sat_t sat_clamp(
        input wide_t sum_ext,
        input int    width
    );
        sat_t r;
        r.ovf = 1'b0;
        r.val = sum_ext;
        if (sum_ext > sat_max(width)) begin
            r.ovf = 1'b1;
            r.val = sat_max(width);
        end else if (sum_ext < sat_min(width)) begin
            r.ovf = 1'b1;
            r.val = sat_min(width);
        end
        return r;
    endfunction

endpackage

// File: rtl/stall_delay_line.sv
// Stall-aware shift register; every stage holds while stall is high.
// DEPTH of zero degenerates to a wire.
module stall_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = ^{clk, reset_n, stall};
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++)
                        stage[i] <= '0;
                end else if (!stall) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++)
                        stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sat_accumulator.sv
// Saturating accumulator: sums len signed fixed-point terms per vector
// and reports each result through a stall-aware output delay line.
module sat_accumulator
    import sa_fixed_pkg::*;
#(
    parameter int IN_WIDTH     = 16,
    parameter int IN_FRAC      = 15,
    parameter int OUTPUT_WIDTH = 32,
    parameter int OUTPUT_FRAC  = 15,
    parameter int LEN_WIDTH    = 8,
    parameter int DELAY        = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    stall,
    input  logic                    clear,
    input  logic [IN_WIDTH-1:0]     data_in,
    input  logic [LEN_WIDTH-1:0]    len,
    output logic [OUTPUT_WIDTH-1:0] acc_out,
    output logic                    done,
    output logic                    overflow,
    output logic                    busy
);

    localparam int SHIFT = OUTPUT_FRAC - IN_FRAC;
    localparam int DW    = OUTPUT_WIDTH + 2;

    state_t                  state, state_nxt;
    logic [OUTPUT_WIDTH-1:0] acc, acc_nxt;
    logic [LEN_WIDTH-1:0]    count, count_nxt, count_inc;
    logic [LEN_WIDTH-1:0]    eff_len, eff_len_nxt, len_eff;
    logic                    ovf, ovf_nxt;
    logic                    accept, complete;

    wide_t                   al_wide;
    logic [OUTPUT_WIDTH-1:0] aligned;
    logic signed [OUTPUT_WIDTH:0] sum_ext;
    sat_t                    clamp;
    logic [DW-1:0]           dl_in, dl_out;
    logic                    unused_hi;

    assign accept    = en && !stall && !clear;
    assign len_eff   = (len == '0) ? LEN_WIDTH'(1) : len;
    assign count_inc = count + LEN_WIDTH'(1);

    assign al_wide = align(wide_t'($signed(data_in)), SHIFT, OUTPUT_WIDTH);
    assign aligned = al_wide[OUTPUT_WIDTH-1:0];
    assign sum_ext = $signed({acc[OUTPUT_WIDTH-1], acc})
                   + $signed({aligned[OUTPUT_WIDTH-1], aligned});
    assign clamp   = sat_clamp(wide_t'(sum_ext), OUTPUT_WIDTH);

    assign unused_hi = ^{al_wide[MAXW-1:OUTPUT_WIDTH],
                         clamp.val[MAXW-1:OUTPUT_WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The first beat loads rather than adds, so no clamp can fire on it.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        count_nxt   = count;
        eff_len_nxt = eff_len;
        ovf_nxt     = ovf;
        complete    = 1'b0;
        unique case (1'b1)
            clear: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                count_nxt = '0;
                ovf_nxt   = 1'b0;
            end
            accept && (state == IDLE): begin
                acc_nxt     = aligned;
                count_nxt   = LEN_WIDTH'(1);
                eff_len_nxt = len_eff;
                ovf_nxt     = 1'b0;
                complete    = (len_eff == LEN_WIDTH'(1));
                state_nxt   = complete ? IDLE : ACCUM;
            end
            accept && (state == ACCUM): begin
                acc_nxt   = clamp.val[OUTPUT_WIDTH-1:0];
                count_nxt = count_inc;
                ovf_nxt   = ovf | clamp.ovf;
                complete  = (count_inc == eff_len);
                state_nxt = complete ? IDLE : ACCUM;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state == ACCUM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            count   <= '0;
            eff_len <= '0;
            ovf     <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            count   <= count_nxt;
            eff_len <= eff_len_nxt;
            ovf     <= ovf_nxt;
        end
    end

    assign dl_in = {complete, ovf_nxt, acc_nxt};

    stall_delay_line #(
        .WIDTH (DW),
        .DEPTH (DELAY - 1)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .d       (dl_in),
        .q       (dl_out)
    );

    // Output stage supplies the last cycle of latency and holds old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            acc_out  <= '0;
        end else if (!stall) begin
            done <= dl_out[DW-1];
            if (dl_out[DW-1]) begin
                overflow <= dl_out[DW-2];
                acc_out  <= dl_out[OUTPUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator: three configurations share one
// stimulus stream; a negedge monitor checks results and timed probes.
module tb_sat_accumulator;

    localparam int P_BUSY   = 0;
    localparam int P_DONE   = 1;
    localparam int P_ACC    = 2;
    localparam int P_OVF    = 3;
    localparam int P_DONE_C = 4;
    localparam int P_ACC_C  = 5;

    logic        clk = 1'b0;
    logic        reset_n, en, stall, clear;
    logic [15:0] data_in;
    logic [7:0]  len;

    logic [31:0] acc_a, acc_c;
    logic [15:0] acc_b;
    logic        done_a, done_b, done_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        busy_a, busy_b, busy_c;

    typedef struct {
        logic [31:0] val;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
    } probe_t;

    exp_t   qa[$], qb[$], qc[$];
    probe_t pq[$];
    exp_t   e;
    int     pi;
    int     cyc   = 0;
    int     total = 0;
    int     bad   = 0;
    logic   end_req = 1'b0;
    logic   end_ack = 1'b0;
    logic   hold_a = 1'b0, hold_b = 1'b0, hold_c = 1'b0;

    sat_accumulator u_a (
        .clk(clk), .reset_n(reset_n), .en(en), .stall(stall),
        .clear(clear), .data_in(data_in), .len(len),
        .acc_out(acc_a), .done(done_a), .overflow(ovf_a), .busy(busy_a)
    );

    sat_accumulator #(.OUTPUT_WIDTH(16)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en), .stall(stall),
        .clear(clear), .data_in(data_in), .len(len),
        .acc_out(acc_b), .done(done_b), .overflow(ovf_b), .busy(busy_b)
    );

    sat_accumulator #(.DELAY(3)) u_c (
        .clk(clk), .reset_n(reset_n), .en(en), .stall(stall),
        .clear(clear), .data_in(data_in), .len(len),
        .acc_out(acc_c), .done(done_c), .overflow(ovf_c), .busy(busy_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] probe_val(input int sig);
        case (sig)
            P_BUSY:   return {29'b0, busy_c, busy_b, busy_a};
            P_DONE:   return {31'b0, done_a};
            P_ACC:    return acc_a;
            P_OVF:    return {31'b0, ovf_a};
            P_DONE_C: return {31'b0, done_c};
            P_ACC_C:  return acc_c;
            default:  return '0;
        endcase
    endfunction

    function automatic string probe_name(input int sig);
        case (sig)
            P_BUSY:   return "busy";
            P_DONE:   return "done_a";
            P_ACC:    return "acc_out_a";
            P_OVF:    return "overflow_a";
            P_DONE_C: return "done_c";
            P_ACC_C:  return "acc_out_c";
            default:  return "unknown";
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        pi = 0;
        while (pi < pq.size()) begin
            if (pq[pi].at == cyc) begin
                cmp(probe_name(pq[pi].sig), probe_val(pq[pi].sig), pq[pi].val);
                pq.delete(pi);
            end else if (pq[pi].at < cyc) begin
                total++;
                bad++;
                $display("FAIL probe_missed: %s at %0d, now %0d",
                         probe_name(pq[pi].sig), pq[pi].at, cyc);
                pq.delete(pi);
            end else begin
                pi++;
            end
        end

        if (done_a && !hold_a) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_spurious: acc_out %h, nothing expected", acc_a);
            end else begin
                e = qa.pop_front();
                cmp("a_result", acc_a, e.val);
                cmp("a_overflow", {31'b0, ovf_a}, {31'b0, e.ovf});
            end
        end
        if (done_b && !hold_b) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_spurious: acc_out %h, nothing expected", acc_b);
            end else begin
                e = qb.pop_front();
                cmp("b_result", {16'b0, acc_b}, e.val);
                cmp("b_overflow", {31'b0, ovf_b}, {31'b0, e.ovf});
            end
        end
        if (done_c && !hold_c) begin
            if (qc.size() == 0) begin
                total++;
                bad++;
                $display("FAIL c_spurious: acc_out %h, nothing expected", acc_c);
            end else begin
                e = qc.pop_front();
                cmp("c_result", acc_c, e.val);
                cmp("c_overflow", {31'b0, ovf_c}, {31'b0, e.ovf});
            end
        end

        // A done seen with stall high is the same pulse on the next cycle.
        hold_a = done_a && stall;
        hold_b = done_b && stall;
        hold_c = done_c && stall;

        if (end_req && !end_ack) begin
            cmp("a_left", 32'(qa.size()), 32'd0);
            cmp("b_left", 32'(qb.size()), 32'd0);
            cmp("c_left", 32'(qc.size()), 32'd0);
            cmp("probes_left", 32'(pq.size()), 32'd0);
            end_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [7:0] l);
        en      = 1'b1;
        data_in = d;
        len     = l;
        step();
        en = 1'b0;
    endtask

    task automatic probe(input int sig, input int dly, input logic [31:0] v);
        probe_t p;
        p.at  = cyc + dly;
        p.sig = sig;
        p.val = v;
        pq.push_back(p);
    endtask

    task automatic expect_all(input logic [31:0] av, input logic ao,
                              input logic [31:0] bv, input logic bo);
        exp_t x;
        x.val = av;
        x.ovf = ao;
        qa.push_back(x);
        qc.push_back(x);
        x.val = bv;
        x.ovf = bo;
        qb.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        stall   = 1'b0;
        clear   = 1'b0;
        data_in = '0;
        len     = '0;
        repeat (3) step();
        probe(P_ACC, 0, 32'd0);
        probe(P_DONE, 0, 32'd0);
        probe(P_BUSY, 0, 32'd0);
        probe(P_OVF, 0, 32'd0);
        probe(P_ACC_C, 0, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();

        // four halves; later beats carry len=1 which must be ignored
        probe(P_BUSY, 0, 32'd0);
        send(16'h4000, 8'd4);
        probe(P_BUSY, 0, 32'd7);
        send(16'h4000, 8'd1);
        probe(P_BUSY, 0, 32'd7);
        send(16'h4000, 8'd1);
        probe(P_BUSY, 0, 32'd7);
        probe(P_DONE, 0, 32'd0);
        send(16'h4000, 8'd1);
        expect_all(32'd65536, 1'b0, 32'h7fff, 1'b1);
        probe(P_BUSY, 0, 32'd0);
        probe(P_DONE, 0, 32'd1);
        probe(P_ACC, 0, 32'd65536);
        probe(P_DONE_C, 0, 32'd0);
        probe(P_DONE_C, 2, 32'd1);
        repeat (3) step();

        // saturation in the narrow config, then clean len=1 and len=0
        send(16'h7000, 8'd2);
        send(16'h7000, 8'd2);
        expect_all(32'h0000e000, 1'b0, 32'h7fff, 1'b1);
        probe(P_DONE, 0, 32'd1);
        probe(P_OVF, 0, 32'd0);
        send(16'h0001, 8'd1);
        expect_all(32'd1, 1'b0, 32'd1, 1'b0);
        probe(P_DONE, 0, 32'd1);
        probe(P_ACC, 0, 32'd1);
        send(16'h0003, 8'd0);
        expect_all(32'd3, 1'b0, 32'd3, 1'b0);
        probe(P_DONE, 0, 32'd1);
        probe(P_ACC, 0, 32'd3);
        probe(P_BUSY, 0, 32'd0);
        repeat (3) step();

        // back-to-back vectors, second one gapped by a cycle
        send(16'd1, 8'd2);
        send(16'd2, 8'd2);
        expect_all(32'd3, 1'b0, 32'd3, 1'b0);
        probe(P_DONE, 0, 32'd1);
        send(16'd3, 8'd2);
        probe(P_DONE, 0, 32'd0);
        step();
        probe(P_DONE, 0, 32'd0);
        send(16'd4, 8'd2);
        expect_all(32'd7, 1'b0, 32'd7, 1'b0);
        probe(P_DONE, 0, 32'd1);
        probe(P_ACC, 0, 32'd7);
        repeat (3) step();

        // stall with en held high after two beats: 10 - 20 + 30
        send(16'd10, 8'd3);
        send(16'hffec, 8'd3);
        stall   = 1'b1;
        en      = 1'b1;
        data_in = 16'd99;
        len     = 8'd3;
        step();
        probe(P_BUSY, 0, 32'd7);
        step();
        step();
        probe(P_DONE, 0, 32'd0);
        stall = 1'b0;
        send(16'd30, 8'd3);
        expect_all(32'd20, 1'b0, 32'd20, 1'b0);
        probe(P_DONE, 0, 32'd1);
        probe(P_ACC, 0, 32'd20);
        repeat (3) step();

        // stall while the deep config presents a result
        send(16'd7, 8'd1);
        expect_all(32'd7, 1'b0, 32'd7, 1'b0);
        send(16'd9, 8'd1);
        expect_all(32'd9, 1'b0, 32'd9, 1'b0);
        step();
        stall = 1'b1;
        probe(P_DONE_C, 0, 32'd1);
        probe(P_ACC_C, 0, 32'd7);
        step();
        probe(P_DONE_C, 0, 32'd1);
        step();
        probe(P_DONE_C, 0, 32'd1);
        probe(P_ACC_C, 0, 32'd7);
        stall = 1'b0;
        step();
        probe(P_DONE_C, 0, 32'd1);
        probe(P_ACC_C, 0, 32'd9);
        step();
        probe(P_DONE_C, 0, 32'd0);
        repeat (3) step();

        // clear with en mid-vector drops the beat and the partial sum
        send(16'd1, 8'd4);
        send(16'd2, 8'd4);
        clear   = 1'b1;
        en      = 1'b1;
        data_in = 16'd100;
        len     = 8'd1;
        step();
        clear = 1'b0;
        en    = 1'b0;
        probe(P_BUSY, 0, 32'd0);
        send(16'd5, 8'd2);
        probe(P_BUSY, 0, 32'd7);
        send(16'd6, 8'd2);
        expect_all(32'd11, 1'b0, 32'd11, 1'b0);
        probe(P_DONE, 0, 32'd1);
        probe(P_ACC, 0, 32'd11);
        repeat (4) step();

        // asynchronous reset between edges, mid-vector
        send(16'd1, 8'd3);
        probe(P_BUSY, 0, 32'd7);
        send(16'd2, 8'd3);
        #2;
        reset_n = 1'b0;
        probe(P_ACC, 0, 32'd0);
        probe(P_ACC_C, 0, 32'd0);
        probe(P_BUSY, 0, 32'd0);
        probe(P_DONE, 0, 32'd0);
        #4;
        reset_n = 1'b1;
        step();
        send(16'hffff, 8'd1);
        expect_all(32'hffffffff, 1'b0, 32'h0000ffff, 1'b0);
        probe(P_DONE, 0, 32'd1);
        probe(P_ACC, 0, 32'hffffffff);

        repeat (8) step();
        end_req = 1'b1;
        wait (end_ack);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
